// File: rtl/arb_mux_n.sv
// ---------------------------------------------------------------------------
// arb_mux_n
//   N-input registered mux/arbiter. Each producer channel has its own
//   valid/ready handshake. One channel is granted per cycle, either by fixed
//   priority (lowest index wins) or by round-robin. The granted word is
//   captured in a one-entry output register that drains through the
//   out_valid/out_ready handshake. Simultaneous drain and load sustain one
//   word per cycle.
//
// Parameters
//   DATA_WIDTH : payload width in bits (>= 1)
//   NUM_IN     : number of input channels (>= 2, any value)
//   ARB_MODE   : 0 = fixed priority, 1 = round-robin
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : per-channel valid
//   in_data   : channel i occupies [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready  : per-channel ready (combinational, at most one bit set)
//   out_valid : output register holds a word
//   out_data  : registered payload of the granted channel
//   out_sel   : index of the channel that supplied out_data
//   out_ready : downstream accepts out_data this cycle
// ---------------------------------------------------------------------------
module arb_mux_n #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    parameter int ARB_MODE   = 1,
    localparam int SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]             out_sel,
    input  logic                         out_ready
);

    // Registered state
    logic                  out_valid_reg, out_valid_next;
    logic [DATA_WIDTH-1:0] out_data_reg,  out_data_next;
    logic [SEL_W-1:0]      out_sel_reg,   out_sel_next;
    logic [SEL_W-1:0]      rr_ptr_reg,    rr_ptr_next;

    // Arbitration results
    logic [DATA_WIDTH-1:0] lane_data [NUM_IN];
    logic [NUM_IN-1:0]     grant;
    logic [SEL_W-1:0]      grant_idx;
    logic                  grant_any;
    logic                  can_load;
    logic                  load;

    // Split the flat input bus into per-channel lanes.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
            assign lane_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Grant selection. The loops run from the lowest-priority candidate
    // to the highest so that the last match (highest priority) wins.
    // Round-robin scans rr_ptr, rr_ptr+1, ... with explicit wrap so that
    // non-power-of-two channel counts never index past NUM_IN-1.
    always_comb begin
        int idx;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant_idx = SEL_W'(i);
                    grant_any = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                idx = int'(rr_ptr_reg) + k;
                if (idx >= NUM_IN) begin
                    idx = idx - NUM_IN;
                end
                if (in_valid[idx]) begin
                    grant_idx = SEL_W'(idx);
                    grant_any = 1'b1;
                end
            end
        end
    end

    assign grant = grant_any ? (NUM_IN'(1) << grant_idx) : '0;

    // The register can take a word if it is empty or is draining this cycle.
    assign can_load = ~out_valid_reg | out_ready;
    assign load     = grant_any & can_load;

    // rst_n is folded in so no channel sees ready while reset is held,
    // even though the empty register would otherwise accept a word.
    assign in_ready = grant & {NUM_IN{can_load & rst_n}};

    // Next-state logic for the output register and round-robin pointer.
    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_sel_next   = out_sel_reg;
        rr_ptr_next    = rr_ptr_reg;
        if (load) begin
            out_valid_next = 1'b1;
            out_data_next  = lane_data[grant_idx];
            out_sel_next   = grant_idx;
            if (ARB_MODE != 0) begin
                rr_ptr_next = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0
                                                                : grant_idx + SEL_W'(1);
            end
        end else if (out_ready) begin
            // Drain without a replacement; payload and index keep their values.
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_sel_reg   <= out_sel_next;
            rr_ptr_reg    <= rr_ptr_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_arb_mux_n.sv
// ---------------------------------------------------------------------------
// tb_arb_mux_n
//   Three instances share the clock and reset:
//     inst 0 : NUM_IN=4, round-robin
//     inst 1 : NUM_IN=4, fixed priority
//     inst 2 : NUM_IN=3, round-robin (non-power-of-two wrap)
//   Directed scenario tasks plus a randomized run against a cycle-level
//   reference model derived from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_arb_mux_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int NN   [3] = '{4, 4, 3};
    localparam int MODE [3] = '{1, 0, 1};

    logic [3:0]   vin  [3];
    logic [127:0] din  [3];
    logic         ordy [3];

    logic [3:0]  rdy [3];
    logic        ov  [3];
    logic [31:0] od  [3];
    logic [1:0]  os  [3];

    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy2;
    logic        ov0, ov1, ov2;
    logic [31:0] od0, od1, od2;
    logic [1:0]  os0, os1, os2;

    arb_mux_n #(.DATA_WIDTH(32), .NUM_IN(4), .ARB_MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .in_data(din[0]),
        .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0),
        .out_ready(ordy[0]));
    arb_mux_n #(.DATA_WIDTH(32), .NUM_IN(4), .ARB_MODE(0)) u_fp4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .in_data(din[1]),
        .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1),
        .out_ready(ordy[1]));
    arb_mux_n #(.DATA_WIDTH(32), .NUM_IN(3), .ARB_MODE(1)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[2][2:0]), .in_data(din[2][95:0]),
        .in_ready(rdy2), .out_valid(ov2), .out_data(od2), .out_sel(os2),
        .out_ready(ordy[2]));

    always_comb begin
        rdy[0] = rdy0; rdy[1] = rdy1; rdy[2] = {1'b0, rdy2};
        ov[0]  = ov0;  ov[1]  = ov1;  ov[2]  = ov2;
        od[0]  = od0;  od[1]  = od1;  od[2]  = od2;
        os[0]  = os0;  os[1]  = os1;  os[2]  = os2;
    end

    // First requesting index in the scan order defined by the mode; -1 if none.
    function automatic int winner(input logic [3:0] v, input int ptr, input int n, input int mode);
        int idx;
        for (int k = 0; k < n; k++) begin
            idx = (mode == 0) ? k : (ptr + k) % n;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic reset_all();
        rst_n = 1'b0;
        for (int j = 0; j < 3; j++) begin
            vin[j] = '0; din[j] = '0; ordy[j] = 1'b1;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int j = 0; j < 3; j++) begin
            vin[j] = (NN[j] == 4) ? 4'hF : 4'h7;
            din[j] = {4{32'h5555_AAAA}};
            ordy[j] = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (ov[j] !== 1'b0) begin n_fail++; $display("FAIL reset_valid inst%0d: got %0b want 0", j, ov[j]); end
            n_checks++;
            if (os[j] !== 2'd0) begin n_fail++; $display("FAIL reset_sel inst%0d: got %0d want 0", j, os[j]); end
            n_checks++;
            if (rdy[j] !== 4'd0) begin n_fail++; $display("FAIL reset_ready inst%0d: got %b want 0000", j, rdy[j]); end
            n_checks++;
            if (od[j] !== 32'd0) begin n_fail++; $display("FAIL reset_data inst%0d: got %h want 0", j, od[j]); end
        end
        $display("reset: checked outputs with all channels requesting");
        reset_all();
    endtask

    task automatic test_rr_fairness();
        reset_all();
        for (int i = 0; i < 4; i++) din[0][i*32 +: 32] = 32'h1000 + i;
        vin[0] = 4'hF;
        #1;
        n_checks++;
        if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL rr_first_valid: got %0b want 0", ov[0]); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ov[0] !== 1'b1 || os[0] !== 2'(c % 4) || od[0] !== 32'h1000 + (c % 4)) begin
                n_fail++;
                $display("FAIL rr_seq c%0d: got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         c, ov[0], os[0], od[0], c % 4, 32'h1000 + (c % 4));
            end
            $display("rr4 cycle %0d: sel %0d data %h", c, os[0], od[0]);
        end
        vin[0] = '0;
    endtask

    task automatic test_fixed_priority();
        reset_all();
        for (int i = 0; i < 4; i++) din[1][i*32 +: 32] = 32'h2000 + i;
        vin[1] = 4'b0110;
        #1;
        n_checks++;
        if (rdy[1] !== 4'b0010) begin n_fail++; $display("FAIL fp_ready: got %b want 0010", rdy[1]); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ov[1] !== 1'b1 || os[1] !== 2'd1 || rdy[1][2] !== 1'b0) begin
                n_fail++;
                $display("FAIL fp_seq c%0d: got v=%0b sel=%0d rdy=%b want v=1 sel=1 rdy[2]=0",
                         c, ov[1], os[1], rdy[1]);
            end
            $display("fp4 cycle %0d: sel %0d data %h", c, os[1], od[1]);
        end
        vin[1] = '0;
    endtask

    task automatic test_backpressure();
        reset_all();
        din[0][0 +: 32] = 32'hDEAD_BEEF;
        vin[0] = 4'b0001;
        ordy[0] = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ov[0] !== 1'b1 || od[0] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL bp_load: got v=%0b data=%h want v=1 data=deadbeef", ov[0], od[0]);
        end
        din[0][32 +: 32] = 32'h1234_5678;
        vin[0] = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (rdy[0] !== 4'b0000) begin n_fail++; $display("FAIL bp_ready c%0d: got %b want 0000", c, rdy[0]); end
            @(posedge clk); #1;
            n_checks++;
            if (ov[0] !== 1'b1 || od[0] !== 32'hDEAD_BEEF || os[0] !== 2'd0) begin
                n_fail++;
                $display("FAIL bp_hold c%0d: got v=%0b data=%h sel=%0d want v=1 data=deadbeef sel=0",
                         c, ov[0], od[0], os[0]);
            end
            $display("bp stall cycle %0d: data %h", c, od[0]);
        end
        ordy[0] = 1'b1;
        #1;
        n_checks++;
        if (rdy[0] !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0010", rdy[0]); end
        @(posedge clk); #1;
        n_checks++;
        if (ov[0] !== 1'b1 || od[0] !== 32'h1234_5678 || os[0] !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_reload: got v=%0b data=%h sel=%0d want v=1 data=12345678 sel=1", ov[0], od[0], os[0]);
        end
        vin[0] = '0;
        @(posedge clk); #1;
        n_checks++;
        if (ov[0] !== 1'b0 || od[0] !== 32'h1234_5678 || os[0] !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_drain: got v=%0b data=%h sel=%0d want v=0 data=12345678 sel=1", ov[0], od[0], os[0]);
        end
        $display("bp release: drained, last data %h", od[0]);
    endtask

    task automatic test_wrap();
        reset_all();
        for (int i = 0; i < 3; i++) din[2][i*32 +: 32] = 32'h3000 + i;
        vin[2] = 4'b0100;
        #1;
        n_checks++;
        if (rdy[2] !== 4'b0100) begin n_fail++; $display("FAIL wrap_ready0: got %b want 0100", rdy[2]); end
        @(posedge clk); #1;
        n_checks++;
        if (os[2] !== 2'd2 || ov[2] !== 1'b1) begin n_fail++; $display("FAIL wrap_sel0: got %0d want 2", os[2]); end
        vin[2] = 4'b0101;
        #1;
        n_checks++;
        if (rdy[2] !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready1: got %b want 0001", rdy[2]); end
        @(posedge clk); #1;
        n_checks++;
        if (os[2] !== 2'd0 || od[2] !== 32'h3000) begin n_fail++; $display("FAIL wrap_sel1: got %0d want 0", os[2]); end
        #1;
        n_checks++;
        if (rdy[2] !== 4'b0100) begin n_fail++; $display("FAIL wrap_ready2: got %b want 0100", rdy[2]); end
        @(posedge clk); #1;
        n_checks++;
        if (os[2] !== 2'd2 || od[2] !== 32'h3002) begin n_fail++; $display("FAIL wrap_sel2: got %0d want 2", os[2]); end
        $display("wrap: grants 2,0,2 on 3-input arbiter");
        vin[2] = '0;
    endtask

    task automatic test_mid_reset();
        reset_all();
        din[0] = {32'h4003, 32'h4002, 32'h4001, 32'h4000};
        vin[0] = 4'b0100;
        ordy[0] = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ov[0] !== 1'b1 || os[0] !== 2'd2) begin n_fail++; $display("FAIL mr_pre: got v=%0b sel=%0d want v=1 sel=2", ov[0], os[0]); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ov[0] !== 1'b0 || os[0] !== 2'd0 || rdy[0] !== 4'b0000) begin
            n_fail++; $display("FAIL mr_async: got v=%0b sel=%0d rdy=%b want v=0 sel=0 rdy=0000", ov[0], os[0], rdy[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        vin[0] = 4'b0100;
        @(posedge clk); #1;
        n_checks++;
        if (ov[0] !== 1'b1 || os[0] !== 2'd2 || od[0] !== 32'h4002) begin
            n_fail++; $display("FAIL mr_after: got v=%0b sel=%0d data=%h want v=1 sel=2 data=00004002", ov[0], os[0], od[0]);
        end
        // Arbitration restarted at index 0 then moved past 2: all-request grants 3 next.
        vin[0] = 4'hF;
        @(posedge clk); #1;
        n_checks++;
        if (os[0] !== 2'd3) begin n_fail++; $display("FAIL mr_ptr: got sel=%0d want 3", os[0]); end
        $display("mid reset: output cleared and restarted");
        vin[0] = '0;
    endtask

    task automatic test_random();
        bit          mv [3];
        logic [31:0] md [3];
        int          ms [3];
        int          mp [3];
        int          w;
        bit          can;
        logic [3:0]  exp_rdy;
        reset_all();
        for (int j = 0; j < 3; j++) begin mv[j] = 0; md[j] = '0; ms[j] = 0; mp[j] = 0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int j = 0; j < 3; j++) begin
                vin[j]  = 4'($urandom) & ((NN[j] == 4) ? 4'hF : 4'h7);
                din[j]  = {$urandom, $urandom, $urandom, $urandom};
                ordy[j] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int j = 0; j < 3; j++) begin
                w = winner(vin[j], mp[j], NN[j], MODE[j]);
                can = !mv[j] || ordy[j];
                exp_rdy = (can && w >= 0) ? (4'b0001 << w) : 4'b0000;
                n_checks++;
                if (rdy[j] !== exp_rdy) begin
                    n_fail++; $display("FAIL rnd_ready inst%0d cyc%0d: got %b want %b", j, cyc, rdy[j], exp_rdy);
                end
                if (can && w >= 0) begin
                    md[j] = din[j][w*32 +: 32];
                    ms[j] = w;
                    mv[j] = 1;
                    if (MODE[j] == 1) mp[j] = (w + 1) % NN[j];
                end else if (mv[j] && ordy[j]) begin
                    mv[j] = 0;
                end
            end
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (ov[j] !== mv[j] || od[j] !== md[j] || os[j] !== 2'(ms[j])) begin
                    n_fail++;
                    $display("FAIL rnd_out inst%0d cyc%0d: got v=%0b data=%h sel=%0d want v=%0b data=%h sel=%0d",
                             j, cyc, ov[j], od[j], os[j], mv[j], md[j], ms[j]);
                end
            end
            if (cyc % 50 == 0)
                $display("rnd cycle %0d: inst0 v=%0b sel=%0d data=%h", cyc, ov[0], os[0], od[0]);
        end
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            vin[j] = '0; din[j] = '0; ordy[j] = 1'b1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
